// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter giving four requesters a register-to-register bus transfer (DRIVE then WRITE).
// Define BUS_ARBITER_R0_PROTECT_EN to make register 0 read-only (rin[0] never asserts).
module bus_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] src_sel,
  input  logic [5*NREQ-1:0] dst_sel,
  output logic [4:0]        select,
  output logic [31:0]       rin,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic [4:0] dst;
  logic [NREQ-1:0] cand;
  logic [31:0] load;
  logic found;
  // the winner's own req is still high when WRITE ends, so it is masked out there
  assign cand = state == WRITE ? req & ~grant : req;
`ifdef BUS_ARBITER_R0_PROTECT_EN
  assign load = (32'd1 << dst) & ~32'd1;
`else
  assign load = 32'd1 << dst;
`endif
  always_comb begin
    found = 1'b0;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[ptr + IW'(k)]) begin
        found = 1'b1;
        pick = ptr + IW'(k);
      end
    end
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      ptr <= '0;
      dst <= '0;
      select <= '0;
      rin <= '0;
      grant <= '0;
      ack <= '0;
      busy <= 1'b0;
    end else if (state == DRIVE) begin
      state <= WRITE;
      rin <= load;
      ack <= grant;
    end else if (found) begin
      state <= DRIVE;
      ptr <= pick + IW'(1);
      select <= src_sel[5*pick +: 5];
      dst <= dst_sel[5*pick +: 5];
      grant <= NREQ'(1) << pick;
      rin <= '0;
      ack <= '0;
      busy <= 1'b1;
    end else begin
      state <= IDLE;
      select <= '0;
      rin <= '0;
      grant <= '0;
      ack <= '0;
      busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
  logic clk = 1'b0, clr_n = 1'b0;
  logic [3:0] req = '0;
  logic [19:0] src_sel = '0, dst_sel = '0;
  logic [4:0] select;
  logic [31:0] rin;
  logic [3:0] grant, ack;
  logic busy;
  int total = 0, bad = 0;
  int ph = 0, win = 0, last = 3;
  logic [4:0] msrc = '0, mdst = '0;

  bus_arbiter dut (.clk(clk), .clr_n(clr_n), .req(req), .src_sel(src_sel), .dst_sel(dst_sel),
                   .select(select), .rin(rin), .grant(grant), .ack(ack), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [31:0] decode(input logic [4:0] d);
`ifdef BUS_ARBITER_R0_PROTECT_EN
    return d == 5'd0 ? 32'd0 : 32'd1 << d;
`else
    return 32'd1 << d;
`endif
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    ph = 0;
    last = 3;
  endtask

  // phase 0 idle, 1 drive, 2 write; next winner is the first asker after the last grant
  task automatic mdl_step();
    logic [3:0] m;
    if (ph == 1) begin
      ph = 2;
      return;
    end
    m = ph == 2 ? req & ~(4'd1 << win) : req;
    ph = 0;
    for (int k = 1; k <= 4; k++) begin
      if (ph == 0 && m[(last + k) % 4]) begin
        win = (last + k) % 4;
        last = win;
        msrc = src_sel[5*win +: 5];
        mdst = dst_sel[5*win +: 5];
        ph = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("select", 32'(select), ph != 0 ? 32'(msrc) : 32'd0);
    chk("grant", 32'(grant), ph != 0 ? 32'd1 << win : 32'd0);
    chk("rin", rin, ph == 2 ? decode(mdst) : 32'd0);
    chk("ack", 32'(ack), ph == 2 ? 32'd1 << win : 32'd0);
    chk("busy", 32'(busy), ph != 0 ? 32'd1 : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr_n) mdl_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_rq(input int i, input logic [4:0] s, input logic [4:0] d);
    src_sel[5*i +: 5] = s;
    dst_sel[5*i +: 5] = d;
  endtask

  task automatic async_reset();
    #2 clr_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_rin", rin, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_rin", rin, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    // single request, src changed during DRIVE must not leak
    req = 4'b0001;
    set_rq(0, 5'd5, 5'd9);
    tick();
    chk("single_drive_sel", 32'(select), 32'd5);
    chk("single_drive_rin", rin, 32'd0);
    set_rq(0, 5'd12, 5'd9);
    tick();
    chk("single_write_sel", 32'(select), 32'd5);
    chk("single_write_rin", rin, 32'h200);
    chk("single_write_ack", 32'(ack), 32'd1);
    req = 4'b0000;
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    // reset in WRITE abandons the transfer
    req = 4'b0010;
    set_rq(1, 5'd3, 5'd4);
    tick();
    tick();
    chk("pre_rst_ack", 32'(ack), 32'd2);
    req = 4'b0000;
    async_reset();
    req = 4'b0100;
    set_rq(2, 5'd6, 5'd6);
    tick();
    chk("post_rst_grant", 32'(grant), 32'd4);
    tick();
    chk("src_eq_dst_rin", rin, 32'h40);
    req = 4'b0000;
    tick();
    async_reset();
    // full contention from a fresh pointer
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_rq(i, 5'(i + 1), 5'(i + 20));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_grant", 32'(grant), 32'd1 << i);
      chk("cont_busy", 32'(busy), 32'd1);
      tick();
      chk("cont_ack", 32'(ack), 32'd1 << i);
      req[i] = 1'b0;
    end
    tick();
    chk("cont_idle", 32'(busy), 32'd0);
    // wrap after last grant 3
    req = 4'b1001;
    tick();
    chk("wrap_first", 32'(grant), 32'd1);
    tick();
    req[0] = 1'b0;
    tick();
    chk("wrap_second", 32'(grant), 32'd8);
    tick();
    req[3] = 1'b0;
    tick();
    // destination register 0
    req = 4'b0001;
    set_rq(0, 5'd7, 5'd0);
    tick();
    chk("r0_select", 32'(select), 32'd7);
    tick();
    chk("r0_ack", 32'(ack), 32'd1);
`ifdef BUS_ARBITER_R0_PROTECT_EN
    chk("r0_rin", rin, 32'd0);
`else
    chk("r0_rin", rin, 32'd1);
`endif
    req = 4'b0000;
    tick();
    // randomized requesters: hold until ack, occasionally drop early or reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 2) == 0) set_rq(i, 5'($urandom), 5'($urandom));
      end
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
